// File: rtl/sequencia_pkg.sv
// Shared types and constants for the keypad-sequence arbiter.
package sequencia_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] R_FALSE = 4'b1000;
  localparam logic [3:0] R_ACAO  = 4'b1001;
  localparam logic [3:0] R_HORA  = 4'b1010;
  localparam logic [3:0] R_TMO   = 4'b1110;
  localparam logic [3:0] R_OVF   = 4'b1111;

  localparam int unsigned TERM_BIT = 3;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/sequencia_arb_rr2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module arb_rr2
  import sequencia_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    if (req_a && req_b) grant_id = ~last_grant;
    else if (req_b)     grant_id = ID_B;
    else                grant_id = ID_A;
  end

endmodule

// File: rtl/sequencia_arb.sv
// Shares one digit-sequence recognizer between keypad requesters A and B,
// one whole session at a time, with timeout and length-overflow aborts.
module sequencia_arb
  import sequencia_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TW          = 8,
  parameter int unsigned MAX_SYMS    = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       a_valid,
  input  logic [6:0] a_sym,
  output logic       a_ready,
  output logic       a_done,
  output logic [3:0] a_result,
  input  logic       b_valid,
  input  logic [6:0] b_sym,
  output logic       b_ready,
  output logic       b_done,
  output logic [3:0] b_result,
  output logic [6:0] rec_sym,
  output logic       rec_ctrl,
  output logic       rec_clr,
  input  logic [3:0] rec_state
);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    SYM_MAX  = 4'(MAX_SYMS);

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last_grant, last_grant_nx;
  logic          wait_ph, wait_ph_nx;
  logic [3:0]    sym_cnt, sym_cnt_nx;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
  logic [6:0]    rec_sym_nx;
  logic          ctrl_nx, clr_nx;
  logic          fin;
  logic [3:0]    fin_res;
  logic          grant_valid, grant_id;
  logic          own_valid;
  logic [6:0]    own_sym;

  arb_rr2 u_rr (
    .req_a       (a_valid),
    .req_b       (b_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign own_valid = (owner == ID_B) ? b_valid : a_valid;
  assign own_sym   = (owner == ID_B) ? b_sym   : a_sym;
  assign a_ready   = (state == S_ISSUE) && (owner == ID_A);
  assign b_ready   = (state == S_ISSUE) && (owner == ID_B);

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    wait_ph_nx    = wait_ph;
    sym_cnt_nx    = sym_cnt;
    tmo_cnt_nx    = tmo_cnt;
    rec_sym_nx    = rec_sym;
    ctrl_nx       = 1'b0;
    fin           = 1'b0;
    fin_res       = '0;
    unique case (state)
      S_IDLE: begin
        if (grant_valid) begin
          owner_nx = grant_id;
          state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        sym_cnt_nx = '0;
        tmo_cnt_nx = '0;
        state_nx   = S_ISSUE;
      end
      S_ISSUE: begin
        if (own_valid) begin
          rec_sym_nx = own_sym;
          ctrl_nx    = 1'b1;
          sym_cnt_nx = sym_cnt + 4'd1;
          tmo_cnt_nx = '0;
          wait_ph_nx = 1'b0;
          state_nx   = S_WAIT;
        end else if (tmo_cnt == TMO_LAST) begin
          fin      = 1'b1;
          fin_res  = R_TMO;
          state_nx = S_DONE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // First cycle carries the strobe; the recognizer answers in the second.
        if (!wait_ph) begin
          wait_ph_nx = 1'b1;
        end else if (rec_state[TERM_BIT]) begin
          fin      = 1'b1;
          fin_res  = rec_state;
          state_nx = S_DONE;
        end else if (sym_cnt == SYM_MAX) begin
          fin      = 1'b1;
          fin_res  = R_OVF;
          state_nx = S_DONE;
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_DONE: begin
        last_grant_nx = owner;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    clr_nx = (state_nx == S_CLEAR) || (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      owner      <= ID_A;
      last_grant <= ID_B;
      wait_ph    <= 1'b0;
      sym_cnt    <= '0;
      tmo_cnt    <= '0;
      rec_sym    <= '0;
      rec_ctrl   <= 1'b0;
      rec_clr    <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_result   <= '0;
      b_result   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      wait_ph    <= wait_ph_nx;
      sym_cnt    <= sym_cnt_nx;
      tmo_cnt    <= tmo_cnt_nx;
      rec_sym    <= rec_sym_nx;
      rec_ctrl   <= ctrl_nx;
      rec_clr    <= clr_nx;
      a_done     <= fin && (owner == ID_A);
      b_done     <= fin && (owner == ID_B);
      if (fin && (owner == ID_A)) a_result <= fin_res;
      if (fin && (owner == ID_B)) b_result <= fin_res;
    end
  end

endmodule

// File: doc/sequencia_arb.md
Name: sequencia_arb

Overview:
- Two-requester scheduler that shares one digit-sequence recognizer (7-bit segment symbol in, strobe, 4-bit state code out) between keypad sources A and B.
- Grants one whole session at a time, round-robin.
- Clears the recognizer at session start, feeds the owner's symbols one per strobe, and watches the returned state code.
- Reports the terminal result back to the owner, with timeout and length-overflow protection.

Parameters:
- TIMEOUT_CYC, 255, idle cycles allowed in ISSUE with no symbol from the owner before the session is aborted (1..2^TW-1).
- TW, 8, width of the timeout counter.
- MAX_SYMS, 8, maximum symbols per session before the session is aborted (1..15).

Ports:
- clk  in  1  system clock, all state on its rising edge
- res  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a symbol
- a_sym  in  7  requester A symbol
- a_ready  out  1  A symbol accepted this cycle when a_valid&a_ready
- a_done  out  1  one-cycle pulse: A session finished
- a_result  out  4  A session result, held from the done pulse until A's next done
- b_valid, b_sym, b_ready, b_done, b_result: same as A, for requester B
- rec_sym  out  7  symbol to the recognizer
- rec_ctrl  out  1  recognizer strobe, registered
- rec_clr  out  1  recognizer clear, active-high, registered
- rec_state  in  4  recognizer state code; bit3=1 means terminal (1000 false, 1001 action, 1010 time)

Behaviour:
- Reset (res=0, asynchronous):
  - FSM goes to IDLE; last_grant=B, so A wins the first tie.
  - All outputs are 0, including results and rec_sym.
  - sym_cnt and tmo_cnt are 0.
- FSM states: IDLE, CLEAR, ISSUE, WAIT, DONE.
- IDLE:
  - If any valid is high, latch owner: the only valid requester; if both, the one not equal to last_grant.
  - Next: CLEAR, with rec_clr=1 during CLEAR.
- CLEAR: one cycle; sym_cnt<=0, tmo_cnt<=0; next ISSUE.
- ISSUE:
  - owner_ready=1 combinationally; the other requester's ready stays 0.
  - On owner valid: rec_sym<=sym, rec_ctrl<=1 for exactly the next cycle, sym_cnt++, tmo_cnt<=0; next WAIT.
  - Otherwise tmo_cnt++. When tmo_cnt==TIMEOUT_CYC-1 with no valid: result<=4'b1110; next DONE.
- WAIT:
  - Lasts two cycles: the strobe cycle, then the sample cycle. rec_state is sampled in the second cycle.
  - If rec_state[3]=1: result<=rec_state; next DONE.
  - Else if sym_cnt==MAX_SYMS: result<=4'b1111; next DONE.
  - Else: next ISSUE.
- DONE:
  - owner_done=1 for one cycle; owner_result updates in the same cycle.
  - rec_clr=1 in the same cycle; last_grant<=owner; next IDLE.
- Latency:
  - IDLE valid to first ready: 2 cycles.
  - Accepted symbol to next ready: 3 cycles.
  - Terminal sample to done: 1 cycle.
- The non-owner's valid is ignored for the whole session and never dropped; it is served at the next IDLE.
- rec_ctrl and rec_clr are never high together.
- rec_sym holds its last value between strobes.
- Reset mid-session: immediate return to IDLE, no done pulse, results cleared to 0. The next session's CLEAR re-initialises the recognizer.
- sym_cnt width is 4 bits; tmo_cnt is TW bits. Neither counter can wrap: both are bounded by the compares above.

Decomposition:
- Package sequencia_pkg holds:
  - FSM state enum (3-bit).
  - Result constants R_FALSE=1000, R_ACAO=1001, R_HORA=1010, R_TMO=1110, R_OVF=1111.
  - Terminal-bit index 3.
- Sub-module arb_rr2: two-input round-robin pick. Inputs: two valids and last_grant. Outputs: grant_valid and grant_id.

Test Plan (bench drives the team's digit-sequence recognizer from rec_*):
- Reset: hold res=0 → all outputs 0. Release with a_valid=b_valid=0 → FSM stays IDLE, rec_clr stays 0.
- A alone sends 0010000, 0100100, 0000010, 1000111, 0111010, 0000000:
  - rec_clr pulses 1 cycle before the first a_ready.
  - Exactly 6 rec_ctrl pulses, each 3 cycles apart.
  - a_done pulses once with a_result=1010; b_done stays 0.
- a_valid and b_valid rise together after reset:
  - A is granted; b_ready stays 0 until a_done.
  - A sends 0010000 then 0101001 → a_result=1000.
  - Next session goes to B even though a_valid is still 1.
- TIMEOUT_CYC=16: A sends 0010000 then drops valid → after 16 cycles in ISSUE, a_done with a_result=1110, then rec_clr=1.
- MAX_SYMS=4: A alternates 0010000/0100100 four times (recognizer never terminal) → a_done after the 4th sample with a_result=1111.
- res pulsed low during WAIT of B's 2nd symbol → outputs 0 immediately, no b_done. Afterwards a fresh session starts with CLEAR and A wins the tie (last_grant reset to B).
